// File: rtl/abcd_stim_pkg.sv
// -----------------------------------------------------------------------------
// abcd_stim_pkg
// Shared definitions for the A/B/C/D stimulus generator:
//   - state_e       : run-control FSM states
//   - MODE_*        : sequence selection encoding
//   - *_LEN         : number of vectors per sequence
//   - last_step()   : index of the final vector for a given mode
// -----------------------------------------------------------------------------
package abcd_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_JOHNSON = 1'b0;
    localparam logic MODE_BINARY  = 1'b1;

    localparam int JOHNSON_LEN = 8;
    localparam int BIN_LEN     = 16;

    // Index of the final vector of a run; the step counter stops here so it
    // never wraps inside a run.
    function automatic logic [3:0] last_step(input logic mode);
        logic [3:0] idx;
        case (mode)
            MODE_BINARY:  idx = 4'(BIN_LEN - 1);
            MODE_JOHNSON: idx = 4'(JOHNSON_LEN - 1);
            default:      idx = 4'(JOHNSON_LEN - 1);
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/johnson_counter_4.sv
// -----------------------------------------------------------------------------
// johnson_counter_4
// 4-bit twisted-ring (Johnson) register. Bit 3 maps to A, bit 0 to D.
// On each enabled cycle A takes ~D and B, C, D shift down one place.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset (clears the ring)
//   clr_i in   synchronous clear (restart the walk at 0000)
//   en_i  in   advance the ring by one position
//   q_o   out  current ring value {A,B,C,D}
//   nxt_o out  value the ring will take on the next enabled cycle
// -----------------------------------------------------------------------------
module johnson_counter_4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [3:0] q_o,
    output logic [3:0] nxt_o
);

    logic [3:0] ring_q;
    logic [3:0] ring_d;

    assign nxt_o = {~ring_q[0], ring_q[3:1]};
    assign q_o   = ring_q;

    // Next ring value: clear has priority over advance.
    always_comb begin
        ring_d = ring_q;
        if (clr_i) begin
            ring_d = 4'b0000;
        end else if (en_i) begin
            ring_d = nxt_o;
        end else begin
            ring_d = ring_q;
        end
    end

    // Ring register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ring_q <= 4'b0000;
        end else begin
            ring_q <= ring_d;
        end
    end

endmodule

// File: rtl/abcd_stim_gen.sv
// -----------------------------------------------------------------------------
// abcd_stim_gen
// Sequential stimulus generator for the A/B/C/D inputs of the and-or-invert
// gate stage. A start pulse in IDLE launches a run through either an 8-vector
// Johnson walk or a 16-vector binary count, each vector held hold+1 cycles.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   start_i     in   run request, honoured only in IDLE
//   mode_i      in   0 = Johnson walk, 1 = binary count (latched at start)
//   hold_i      in   cycles per vector minus one (latched at start)
//   a_o..d_o    out  registered stimulus bits
//   vec_valid_o out  pulse in the first cycle of each new vector
//   step_o      out  0-based index of the current vector
//   busy_o      out  high while running
//   done_o      out  pulse in the cycle after the last vector
// -----------------------------------------------------------------------------
module abcd_stim_gen
    import abcd_stim_pkg::*;
#(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [HOLD_W-1:0] hold_i,
    output logic              a_o,
    output logic              b_o,
    output logic              c_o,
    output logic              d_o,
    output logic              vec_valid_o,
    output logic [3:0]        step_o,
    output logic              busy_o,
    output logic              done_o
);

    state_e            state_q, state_d;
    logic              mode_q, mode_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [3:0]        step_q, step_d;
    logic [3:0]        abcd_q, abcd_d;
    logic              vv_q, vv_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              jc_clr_s;
    logic              jc_en_s;
    logic [3:0]        jc_q_s;
    logic [3:0]        jc_nxt_s;

    johnson_counter_4 u_johnson (
        .clk   (clk),
        .rst   (rst),
        .clr_i (jc_clr_s),
        .en_i  (jc_en_s),
        .q_o   (jc_q_s),
        .nxt_o (jc_nxt_s)
    );

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // so every port comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        abcd_d   = abcd_q;
        vv_d     = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        jc_clr_s = 1'b0;
        jc_en_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = RUN;
                    mode_d   = mode_i;
                    hold_d   = hold_i;
                    cnt_d    = '0;
                    step_d   = 4'd0;
                    abcd_d   = 4'b0000;
                    vv_d     = 1'b1;
                    busy_d   = 1'b1;
                    jc_clr_s = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            RUN: begin
                if (cnt_q == hold_q) begin
                    cnt_d = '0;
                    if (step_q == last_step(mode_q)) begin
                        // Final hold expired: drop the stimulus and report.
                        state_d  = DONE;
                        step_d   = 4'd0;
                        abcd_d   = 4'b0000;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        jc_clr_s = 1'b1;
                    end else begin
                        step_d = step_q + 4'd1;
                        vv_d   = 1'b1;
                        if (mode_q == MODE_BINARY) begin
                            abcd_d = step_q + 4'd1;
                        end else begin
                            // The ring only moves on a vector change, so its
                            // next value is exactly the next Johnson vector.
                            abcd_d  = jc_nxt_s;
                            jc_en_s = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                step_d   = 4'd0;
                abcd_d   = 4'b0000;
                busy_d   = 1'b0;
                jc_clr_s = 1'b1;
            end
        endcase
    end

    // State and output registers; reset overrides any start request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_JOHNSON;
            hold_q  <= '0;
            cnt_q   <= '0;
            step_q  <= 4'd0;
            abcd_q  <= 4'b0000;
            vv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            abcd_q  <= abcd_d;
            vv_q    <= vv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a_o         = abcd_q[3];
    assign b_o         = abcd_q[2];
    assign c_o         = abcd_q[1];
    assign d_o         = abcd_q[0];
    assign vec_valid_o = vv_q;
    assign step_o      = step_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
